// File: rtl/keypad_value_entry_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_value_entry_if                                      |
// | Description : Keypad pins and decoded value outputs of the entry block.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface keypad_value_entry_if;
   logic [3:0]  key_row;
   logic [2:0]  key_col;
   logic [11:0] entry_bcd;
   logic [1:0]  digit_count;
   logic [7:0]  binary_value;
   logic        value_valid;
   logic        entry_error;

   modport master (
      input  key_row,
      output key_col, entry_bcd, digit_count, binary_value, value_valid, entry_error
   );

   modport slave (
      output key_row,
      input  key_col, entry_bcd, digit_count, binary_value, value_valid, entry_error
   );
endinterface
`default_nettype wire

// File: rtl/keypad_value_entry.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_value_entry                                         |
// | Description : 3x4 keypad scanner/debouncer collecting 3 BCD digits and   |
// |               converting them to an 8-bit binary value on '#'.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module keypad_value_entry #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   keypad_value_entry_if.master  bus
);

   localparam int         c_DIV_W     = $clog2(SCAN_DIV);
   localparam int         c_DB_W      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_DB_W-1:0]  c_DB_TARGET = c_DB_W'(DEBOUNCE_SCANS);
   localparam logic [c_DB_W-1:0]  c_DB_ONE    = c_DB_W'(1);
   localparam logic [3:0] c_KEY_STAR  = 4'd10;
   localparam logic [3:0] c_KEY_HASH  = 4'd11;
   localparam logic [3:0] c_KEY_NONE  = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_PRESS_WAIT   = 2'd1,
      S_HELD         = 2'd2,
      S_RELEASE_WAIT = 2'd3
   } state_t;

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [2:0] col);
      logic [3:0] idx;
      idx = col[2] ? 4'd2 : (col[1] ? 4'd1 : 4'd0);
      if (row == 2'd3)
         key_code = (idx == 4'd0) ? c_KEY_STAR : ((idx == 4'd1) ? 4'd0 : c_KEY_HASH);
      else
         key_code = ({2'b00, row} * 4'd3) + idx + 4'd1;
   endfunction

   logic [3:0]         r_row_meta;
   logic [3:0]         r_row_sync;
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [2:0]         r_col;
   logic [1:0]         r_hits;
   logic [3:0]         r_code;
   state_t             r_state;
   logic [c_DB_W-1:0]  r_db_cnt;
   logic [3:0]         r_cand;
   logic [11:0]        r_entry_bcd;
   logic [1:0]         r_digit_cnt;
   logic [7:0]         r_binary;
   logic               r_valid;
   logic               r_error;

   logic               w_slot_end;
   logic               w_round_end;
   logic [2:0]         w_slot_hits;
   logic [3:0]         w_slot_code;
   logic [2:0]         w_hits_sum;
   logic [1:0]         w_total;
   logic [3:0]         w_code_acc;
   logic [3:0]         w_round_code;
   state_t             w_state_nxt;
   logic [c_DB_W-1:0]  w_db_nxt;
   logic [c_DB_W-1:0]  w_db_inc;
   logic [3:0]         w_cand_nxt;
   logic               w_event;
   logic [3:0]         w_event_code;
   logic [9:0]         w_h10;
   logic [9:0]         w_t10;
   logic [9:0]         w_u10;
   logic [9:0]         w_value;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_row_meta <= '0;
         r_row_sync <= '0;
      end else begin
         r_row_meta <= bus.key_row;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_slot_end  = (r_div_cnt == c_DIV_LAST);
   assign w_round_end = w_slot_end && r_col[2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_cnt <= '0;
         r_col     <= 3'b001;
      end else if (w_slot_end) begin
         r_div_cnt <= '0;
         r_col     <= {r_col[1:0], r_col[2]};
      end else begin
         r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end
   end

   // Contacts are counted across the whole round; only exactly one yields a key code.
   always_comb begin
      w_slot_hits = 3'd0;
      w_slot_code = c_KEY_NONE;
      for (int r = 0; r < 4; r++) begin
         if (r_row_sync[r]) begin
            w_slot_hits = w_slot_hits + 3'd1;
            w_slot_code = key_code(2'(r), r_col);
         end
      end
      w_hits_sum   = {1'b0, r_hits} + w_slot_hits;
      w_total      = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
      w_code_acc   = (w_slot_hits == 3'd1) ? w_slot_code : r_code;
      w_round_code = (w_total == 2'd1) ? w_code_acc : c_KEY_NONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hits <= 2'd0;
         r_code <= c_KEY_NONE;
      end else if (w_slot_end) begin
         if (r_col[2]) begin
            r_hits <= 2'd0;
            r_code <= c_KEY_NONE;
         end else begin
            r_hits <= w_total;
            r_code <= w_code_acc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_db_cnt <= '0;
         r_cand   <= c_KEY_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_db_cnt <= w_db_nxt;
         r_cand   <= w_cand_nxt;
      end
   end

   assign w_db_inc = r_db_cnt + c_DB_ONE;

   always_comb begin
      w_state_nxt  = r_state;
      w_db_nxt     = r_db_cnt;
      w_cand_nxt   = r_cand;
      w_event      = 1'b0;
      w_event_code = r_cand;
      if (w_round_end) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_round_code != c_KEY_NONE) begin
                  w_cand_nxt = w_round_code;
                  w_db_nxt   = c_DB_ONE;
                  if (c_DB_TARGET == c_DB_ONE) begin
                     w_event      = 1'b1;
                     w_event_code = w_round_code;
                     w_state_nxt  = S_HELD;
                  end else begin
                     w_state_nxt = S_PRESS_WAIT;
                  end
               end
            end
            S_PRESS_WAIT: begin
               if (w_round_code == r_cand) begin
                  w_db_nxt = w_db_inc;
                  if (w_db_inc == c_DB_TARGET) begin
                     w_event     = 1'b1;
                     w_state_nxt = S_HELD;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_HELD: begin
               // The first empty round counts toward the release debounce.
               if (w_round_code == c_KEY_NONE) begin
                  w_db_nxt    = c_DB_ONE;
                  w_state_nxt = (c_DB_TARGET == c_DB_ONE) ? S_IDLE : S_RELEASE_WAIT;
               end
            end
            S_RELEASE_WAIT: begin
               if (w_round_code == c_KEY_NONE) begin
                  w_db_nxt = w_db_inc;
                  if (w_db_inc == c_DB_TARGET)
                     w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_HELD;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_h10   = {6'd0, r_entry_bcd[11:8]};
   assign w_t10   = {6'd0, r_entry_bcd[7:4]};
   assign w_u10   = {6'd0, r_entry_bcd[3:0]};
   assign w_value = (w_h10 << 6) + (w_h10 << 5) + (w_h10 << 2)
                  + (w_t10 << 3) + (w_t10 << 1) + w_u10;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_entry_bcd <= '0;
         r_digit_cnt <= 2'd0;
         r_binary    <= 8'd0;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (w_event) begin
            if (w_event_code <= 4'd9) begin
               if (r_digit_cnt != 2'd3) begin
                  r_entry_bcd <= {r_entry_bcd[7:0], w_event_code};
                  r_digit_cnt <= r_digit_cnt + 2'd1;
               end
            end else if (w_event_code == c_KEY_STAR) begin
               r_entry_bcd <= '0;
               r_digit_cnt <= 2'd0;
            end else if (w_event_code == c_KEY_HASH && r_digit_cnt != 2'd0) begin
               if (w_value <= 10'd255) begin
                  r_binary <= w_value[7:0];
                  r_valid  <= 1'b1;
               end else begin
                  r_error  <= 1'b1;
               end
               r_entry_bcd <= '0;
               r_digit_cnt <= 2'd0;
            end
         end
      end
   end

   assign bus.key_col      = r_col;
   assign bus.entry_bcd    = r_entry_bcd;
   assign bus.digit_count  = r_digit_cnt;
   assign bus.binary_value = r_binary;
   assign bus.value_valid  = r_valid;
   assign bus.entry_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_keypad_value_entry.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_keypad_value_entry                                      |
// | Description : Keypad matrix model, digit-entry reference and scoreboard. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_keypad_value_entry;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 2;
   localparam int ROUND    = 3 * SCAN_DIV;

   typedef struct packed {
      logic [11:0] bcd;
      logic [1:0]  cnt;
      logic [7:0]  bin;
      logic        v;
      logic        e;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] pressed = '0;
   int          n_cmp = 0;
   int          n_err = 0;
   obs_t        exp_q[$];
   int          m_digits[$];
   int          m_bin = 0;

   keypad_value_entry_if bus();

   keypad_value_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Physical matrix: a closed switch connects its column drive to its row.
   always_comb begin
      bus.key_row = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && bus.key_col[c]) bus.key_row[r] = 1'b1;
   end

   function automatic int keypos(input int k);
      if (k >= 1 && k <= 9) return k - 1;
      if (k == 0)  return 10;
      if (k == 10) return 9;
      return 11;
   endfunction

   function automatic obs_t model_obs(input bit v, input bit e);
      obs_t o;
      int   b;
      b = 0;
      foreach (m_digits[i]) b = b * 16 + m_digits[i];
      o.bcd = 12'(b);
      o.cnt = 2'(m_digits.size());
      o.bin = 8'(m_bin);
      o.v   = v;
      o.e   = e;
      return o;
   endfunction

   // Calculator-style entry: up to three digits, '*' clears, '#' commits.
   task automatic model_key(input int k);
      bit changed, v, e;
      int val;
      changed = 0; v = 0; e = 0;
      if (k <= 9) begin
         if (m_digits.size() < 3) begin
            m_digits.push_back(k);
            changed = 1;
         end
      end else if (k == 10) begin
         if (m_digits.size() > 0) changed = 1;
         m_digits.delete();
      end else if (m_digits.size() > 0) begin
         val = 0;
         foreach (m_digits[i]) val = val * 10 + m_digits[i];
         if (val <= 255) begin
            m_bin = val;
            v = 1;
         end else begin
            e = 1;
         end
         m_digits.delete();
         changed = 1;
      end
      if (changed) exp_q.push_back(model_obs(v, e));
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {5'd0, bus.key_col, bus.entry_bcd, bus.digit_count, bus.binary_value,
                   bus.value_valid, bus.entry_error}, {5'd0, 3'b001, 24'd0});
   endtask

   task automatic press(input int k, input int hold_rounds, input int gap_rounds);
      @(negedge clk);
      model_key(k);
      pressed = '0;
      pressed[keypos(k)] = 1'b1;
      repeat (hold_rounds * ROUND) @(negedge clk);
      pressed = '0;
      repeat (gap_rounds * ROUND) @(negedge clk);
   endtask

   task automatic glitch(input int k);
      @(negedge clk);
      pressed = '0;
      pressed[keypos(k)] = 1'b1;
      repeat (ROUND) @(negedge clk);
      pressed = '0;
      repeat (6 * ROUND) @(negedge clk);
   endtask

   task automatic model_reset();
      check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      m_digits.delete();
      m_bin = 0;
   endtask

   // Monitor: every visible output change or pulse must match the next expected entry.
   initial begin
      obs_t cur, prev, want;
      prev = '0;
      forever begin
         @(negedge clk);
         cur.bcd = bus.entry_bcd;
         cur.cnt = bus.digit_count;
         cur.bin = bus.binary_value;
         cur.v   = bus.value_valid;
         cur.e   = bus.entry_error;
         if (!rst) begin
            prev = cur;
            continue;
         end
         if (cur.v || cur.e || cur.bcd != prev.bcd || cur.cnt != prev.cnt || cur.bin != prev.bin) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output got bcd=%h cnt=%0d bin=%0d v=%b e=%b at %0t",
                        cur.bcd, cur.cnt, cur.bin, cur.v, cur.e, $time);
            end else begin
               want = exp_q.pop_front();
               if (cur !== want) begin
                  n_err++;
                  $display("FAIL event_output got bcd=%h cnt=%0d bin=%0d v=%b e=%b expected bcd=%h cnt=%0d bin=%0d v=%b e=%b at %0t",
                           cur.bcd, cur.cnt, cur.bin, cur.v, cur.e,
                           want.bcd, want.cnt, want.bin, want.v, want.e, $time);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // T1: asynchronous clear mid-scan, then column rotation
      press(7, 4, 4);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1 check_reset_outputs("t1_async_reset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      #1 check("t1_col_k0", 32'(bus.key_col), 32'b001);
      for (int i = 1; i < 16; i++) begin
         logic [2:0] want_col;
         @(negedge clk);
         want_col = 3'b001 << ((i / SCAN_DIV) % 3);
         check($sformatf("t1_col_k%0d", i), 32'(bus.key_col), 32'(want_col));
      end
      repeat (2 * ROUND) @(negedge clk);

      // T2..T4: directed entries
      press(1, 4, 4); press(2, 4, 4); press(8, 4, 4); press(11, 4, 4);
      press(2, 4, 4); press(5, 4, 4); press(6, 4, 4); press(11, 4, 4);
      press(2, 4, 4); press(5, 4, 4); press(5, 4, 4); press(11, 4, 4);
      press(9, 4, 4); press(9, 4, 4); press(9, 4, 4); press(7, 4, 4);
      press(10, 4, 4); press(11, 4, 4);

      // T5: bounce and long hold
      glitch(3);
      press(5, 20, 6);
      @(negedge clk);
      model_key(5);
      pressed = '0; pressed[keypos(5)] = 1'b1;
      repeat (5 * ROUND) @(negedge clk);
      pressed = '0;
      repeat (ROUND) @(negedge clk);
      pressed[keypos(5)] = 1'b1;
      repeat (5 * ROUND) @(negedge clk);
      pressed = '0;
      repeat (6 * ROUND) @(negedge clk);
      press(10, 4, 4);

      // T6: two keys at once, then reset while a press is debouncing
      @(negedge clk);
      pressed = '0; pressed[keypos(1)] = 1'b1; pressed[keypos(2)] = 1'b1;
      repeat (8 * ROUND) @(negedge clk);
      pressed = '0;
      repeat (6 * ROUND) @(negedge clk);
      press(4, 4, 4);
      @(negedge clk);
      pressed[keypos(3)] = 1'b1;
      repeat (14) @(negedge clk);
      rst = 1'b0;
      #1 check_reset_outputs("t6_reset_in_press_wait");
      model_reset();
      pressed = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (8 * ROUND) @(negedge clk);
      press(4, 4, 4); press(11, 4, 4);

      // Randomized key sequences
      for (int n = 0; n < 40; n++) begin
         k = (($urandom_range(0, 3) == 0) ? $urandom_range(10, 11) : $urandom_range(0, 9));
         press(k, $urandom_range(3, 8), $urandom_range(3, 8));
      end

      repeat (10 * ROUND) @(negedge clk);
      check("final_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
